// File: rtl/led_player_pkg.sv
// Shared definitions for the LED pattern player.
//   - Default RAM geometry (word-address and data widths).
//   - Constant Avalon byteenable for full-word reads.
//   - FSM state encoding, kept as plain logic constants for legacy tools.
package led_player_pkg;

  localparam int unsigned DEF_ADDR_W = 15;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned MEM_BE_W   = 4;

  localparam logic [MEM_BE_W-1:0] MEM_BYTEENABLE = 4'hF;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StFetch   = 2'd1;
  localparam state_t StCapture = 2'd2;
  localparam state_t StDwell   = 2'd3;

endpackage

// File: rtl/led_pattern_player_if.sv
// Avalon-MM read-master bundle between the LED player and the on-chip RAM.
//   mem_grant      arbiter permits an access this cycle (slave -> master)
//   mem_address    RAM word address                     (master -> slave)
//   mem_chipselect read request                         (master -> slave)
//   mem_write      always 0                             (master -> slave)
//   mem_byteenable always all ones                      (master -> slave)
//   mem_clken      always 1                             (master -> slave)
//   mem_readdata   RAM output, valid 1 cycle after an accepted read
interface led_pattern_player_if
  import led_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic                mem_grant;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_write;
  logic [MEM_BE_W-1:0] mem_byteenable;
  logic                mem_clken;
  logic [DATA_W-1:0]   mem_readdata;

  modport master (
    input  mem_grant,
    input  mem_readdata,
    output mem_address,
    output mem_chipselect,
    output mem_write,
    output mem_byteenable,
    output mem_clken
  );

  modport slave (
    output mem_grant,
    output mem_readdata,
    input  mem_address,
    input  mem_chipselect,
    input  mem_write,
    input  mem_byteenable,
    input  mem_clken
  );

endinterface

// File: rtl/led_player_index.sv
// Table index sequencer for the LED pattern player.
//   clk, reset  system clock, synchronous active-high reset
//   clear       restart at index 0 (direction up)
//   advance     step to the next table entry
//   last        highest valid index (table length - 1)
//   idx         current table index
//   wrap        1-cycle pulse on the step that lands on index 0
// Build option: LED_PLAYER_PINGPONG_EN bounces between 0 and last instead of
// looping forward; end entries are not repeated.
module led_player_index
  import led_player_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] idx,
  output logic              wrap
);

  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              wrap_q, wrap_d;

`ifdef LED_PLAYER_PINGPONG_EN
  logic down_q, down_d;

  always_comb begin
    idx_d  = idx_q;
    down_d = down_q;
    wrap_d = 1'b0;
    if (clear) begin
      idx_d  = '0;
      down_d = 1'b0;
    end else if (advance) begin
      if (last == '0) begin
        idx_d = '0;
      end else if (!down_q) begin
        if (idx_q == last) begin
          down_d = 1'b1;
          idx_d  = idx_q - 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        if (idx_q == '0) begin
          down_d = 1'b0;
          idx_d  = idx_q + 1'b1;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      wrap_d = (idx_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      down_q <= 1'b0;
    end else begin
      down_q <= down_d;
    end
  end
`else
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (clear) begin
      idx_d = '0;
    end else if (advance) begin
      idx_d  = (idx_q == last) ? '0 : idx_q + 1'b1;
      wrap_d = (idx_q == last);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/led_pattern_player.sv
// LED pattern player: Avalon-MM read master that fetches a table of pattern
// words from on-chip RAM and shows each on the LEDs for a programmable dwell.
//   clk, reset       system clock, synchronous active-high reset
//   start            begin playback from base_addr (honoured only when idle)
//   stop             abort to idle on the next edge; overrides everything
//   base_addr        first table word (latched on start)
//   length           table length in words, 0 behaves as 1 (latched on start)
//   dwell            display cycles per word minus 1 (latched on start)
//   bus              RAM read-master port (led_pattern_player_if.master)
//   led              current pattern (low LED_W bits of the fetched word)
//   busy             high in every state except idle
//   wrap             1-cycle pulse when the index returns to base_addr
// Build option: LED_PLAYER_PINGPONG_EN selects ping-pong table traversal.
module led_pattern_player
  import led_player_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LED_W   = 18,
  parameter int unsigned DWELL_W = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    length,
  input  logic [DWELL_W-1:0]   dwell,
  led_pattern_player_if.master bus,
  output logic [LED_W-1:0]     led,
  output logic                 busy,
  output logic                 wrap
);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  last_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] dcnt_q;
  logic [LED_W-1:0]   led_q;

  logic [ADDR_W-1:0]  len_last;
  logic [ADDR_W-1:0]  idx;
  logic               load;
  logic               capture;
  logic               count;
  logic               advance;

  // A zero length plays a one-word table.
  assign len_last = (length == '0) ? '0 : length - 1'b1;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    capture = 1'b0;
    count   = 1'b0;
    advance = 1'b0;
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StFetch;
            load    = 1'b1;
          end
        end
        StFetch: begin
          // Address and chipselect hold until the arbiter grants.
          if (bus.mem_grant) begin
            state_d = StCapture;
          end
        end
        StCapture: begin
          capture = 1'b1;
          state_d = StDwell;
        end
        StDwell: begin
          if (dcnt_q == '0) begin
            advance = 1'b1;
            state_d = StFetch;
          end else begin
            count = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      base_q  <= '0;
      last_q  <= '0;
      dwell_q <= '0;
      dcnt_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        base_q  <= base_addr;
        last_q  <= len_last;
        dwell_q <= dwell;
      end
      if (capture) begin
        led_q  <= bus.mem_readdata[LED_W-1:0];
        dcnt_q <= dwell_q;
      end else if (count) begin
        dcnt_q <= dcnt_q - 1'b1;
      end
    end
  end

  led_player_index #(
    .ADDR_W (ADDR_W)
  ) u_index (
    .clk     (clk),
    .reset   (reset),
    .clear   (load),
    .advance (advance),
    .last    (last_q),
    .idx     (idx),
    .wrap    (wrap)
  );

  // Address arithmetic wraps naturally at the top of RAM.
  assign bus.mem_address    = base_q + idx;
  assign bus.mem_chipselect = (state_q == StFetch);
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = MEM_BYTEENABLE;
  assign bus.mem_clken      = 1'b1;

  assign led  = led_q;
  assign busy = (state_q != StIdle);

  // Upper readdata bits are intentionally ignored.
  if (LED_W < DATA_W) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^bus.mem_readdata[DATA_W-1:LED_W];
  end

endmodule

// File: tb/tb_led_pattern_player.sv
`timescale 1ns/1ps
module tb_led_pattern_player;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LED_W     = 18;
  localparam int unsigned DWELL_W   = 26;
  localparam int unsigned MEM_WORDS = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start, stop;
  logic [ADDR_W-1:0]  base_addr, length;
  logic [DWELL_W-1:0] dwell;
  logic [LED_W-1:0]   led;
  logic               busy, wrap;

  led_pattern_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  led_pattern_player #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LED_W   (LED_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .base_addr (base_addr),
    .length    (length),
    .dwell     (dwell),
    .bus       (bus_if),
    .led       (led),
    .busy      (busy),
    .wrap      (wrap)
  );

  // RAM with one cycle read latency.
  logic [DATA_W-1:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (bus_if.mem_chipselect && bus_if.mem_grant) bus_if.mem_readdata <= ram[bus_if.mem_address];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model: playback as a sequence of "fetch until granted, then
  // show the word from the 2nd edge after acceptance, next fetch dwell+2
  // edges after acceptance".
  bit               m_busy, m_fetch, m_down, m_wrap;
  int               m_age, m_base, m_len, m_dwell, m_idx;
  logic [LED_W-1:0] m_led;
  logic [DATA_W-1:0] m_word;

  int acc_addr[$];
  int acc_cyc[$];
  int led_val[$];
  int led_cyc[$];
  int wrap_cnt;
  logic [LED_W-1:0] prev_led = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_advance();
`ifdef LED_PLAYER_PINGPONG_EN
    if (m_len == 1) m_idx = 0;
    else if (!m_down) begin
      if (m_idx == m_len - 1) begin m_down = 1; m_idx--; end
      else m_idx++;
    end else begin
      if (m_idx == 0) begin m_down = 0; m_idx++; end
      else m_idx--;
    end
`else
    m_idx = (m_idx + 1) % m_len;
`endif
    m_wrap = (m_idx == 0);
  endtask

  task automatic model_step();
    m_wrap = 0;
    if (reset) begin
      m_busy = 0; m_fetch = 0; m_led = '0; m_idx = 0; m_base = 0; m_age = 0; m_down = 0;
    end else if (stop) begin
      m_busy = 0; m_fetch = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_base = int'(base_addr); m_len = (length == 0) ? 1 : int'(length);
        m_dwell = int'(dwell); m_idx = 0; m_down = 0; m_busy = 1; m_fetch = 1;
      end
    end else if (m_fetch) begin
      if (bus_if.mem_grant) begin
        m_fetch = 0; m_age = 0;
        m_word = ram[(m_base + m_idx) % MEM_WORDS];
      end
    end else begin
      m_age++;
      if (m_age == 1) m_led = m_word[LED_W-1:0];
      if (m_age == m_dwell + 2) begin model_advance(); m_fetch = 1; end
    end
  endtask

  task automatic compare();
    chk("busy", busy, m_busy);
    chk("chipselect", bus_if.mem_chipselect, m_busy && m_fetch);
    if (m_busy && m_fetch) chk("address", bus_if.mem_address, (m_base + m_idx) % MEM_WORDS);
    chk("led", led, m_led);
    chk("wrap", wrap, m_wrap);
    chk("mem_write", bus_if.mem_write, 1'b0);
    chk("byteenable", bus_if.mem_byteenable, 4'hF);
    chk("clken", bus_if.mem_clken, 1'b1);
  endtask

  task automatic tick();
    if (bus_if.mem_chipselect === 1'b1 && bus_if.mem_grant === 1'b1) begin
      acc_addr.push_back(int'(bus_if.mem_address));
      acc_cyc.push_back(cyc);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (wrap === 1'b1) wrap_cnt++;
    if (led !== prev_led) begin
      led_val.push_back(int'(led));
      led_cyc.push_back(cyc);
      prev_led = led;
    end
  endtask

  task automatic do_stop();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic do_start(input int b, input int l, input int d);
    base_addr = ADDR_W'(b); length = ADDR_W'(l); dwell = DWELL_W'(d);
    acc_addr.delete(); acc_cyc.delete(); led_val.delete(); led_cyc.delete();
    wrap_cnt = 0;
    start = 1; tick(); start = 0;
  endtask

  task automatic wait_cs(input int bound);
    for (int i = 0; i < bound && bus_if.mem_chipselect !== 1'b1; i++) tick();
    chk("wait_chipselect", bus_if.mem_chipselect, 1'b1);
  endtask

  initial begin
    int t0, n0, a0;
    reset = 1; start = 0; stop = 0; base_addr = '0; length = '0; dwell = '0;
    bus_if.mem_grant = 1'b1;
    for (int i = 0; i < int'(MEM_WORDS); i++) ram[i] = $urandom;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_led", led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cs", bus_if.mem_chipselect, 0);
    chk("rst_addr", bus_if.mem_address, 0);
    chk("rst_wrap", wrap, 0);

    // Basic loop.
    ram[16] = 32'h1; ram[17] = 32'h2; ram[18] = 32'h4;
    do_start(16, 3, 4);
    repeat (40) tick();
    chk("basic_led0", led_val.size() > 3 ? led_val[0] : -1, 1);
    chk("basic_led1", led_val.size() > 3 ? led_val[1] : -1, 2);
    chk("basic_led2", led_val.size() > 3 ? led_val[2] : -1, 4);
    chk("basic_gap", led_val.size() > 3 ? led_cyc[3] - led_cyc[2] : -1, 7);
    chk("basic_gap01", led_val.size() > 3 ? led_cyc[1] - led_cyc[0] : -1, 7);
`ifdef LED_PLAYER_PINGPONG_EN
    chk("basic_led3", led_val.size() > 3 ? led_val[3] : -1, 2);
    chk("pp_addr3", acc_addr.size() > 5 ? acc_addr[3] : -1, 17);
    chk("pp_addr4", acc_addr.size() > 5 ? acc_addr[4] : -1, 16);
    chk("pp_addr5", acc_addr.size() > 5 ? acc_addr[5] : -1, 17);
`else
    chk("basic_led3", led_val.size() > 3 ? led_val[3] : -1, 1);
    chk("basic_addr3", acc_addr.size() > 3 ? acc_addr[3] : -1, 16);
`endif
    chk("basic_wrap_seen", wrap_cnt > 0, 1);

    // Stop during the dwell of word 2.
    for (int i = 0; i < 30 && led === 18'd2; i++) tick();
    for (int i = 0; i < 30 && led !== 18'd2; i++) tick();
    repeat (2) tick();
    do_stop();
    chk("stop_busy", busy, 0);
    chk("stop_led", led, 2);
    n0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_if.mem_chipselect !== 1'b0) n0++;
    end
    chk("stop_no_cs", n0, 0);

    // Restart from base.
    do_start(16, 3, 4);
    repeat (20) tick();
    chk("restart_addr", acc_addr.size() > 0 ? acc_addr[0] : -1, 16);
    chk("restart_led", led_val.size() > 0 ? led_val[0] : -1, 1);

    // Grant stall of 5 cycles.
    wait_cs(20);
    t0 = cyc; a0 = int'(bus_if.mem_address);
    bus_if.mem_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_cs", bus_if.mem_chipselect, 1);
      chk("stall_addr", bus_if.mem_address, a0);
    end
    bus_if.mem_grant = 1'b1;
    n0 = acc_addr.size();
    led_val.delete(); led_cyc.delete();
    repeat (4) tick();
    chk("stall_one_fetch", acc_addr.size() - n0, 1);
    chk("stall_led_time", led_cyc.size() > 0 ? led_cyc[0] - t0 : -1, 7);

    // Address wrap at the top of RAM.
    do_stop();
    ram[32767] = 32'h0003_AAAA; ram[0] = 32'h0001_5555;
    do_start(32767, 2, 1);
    repeat (20) tick();
    chk("awrap_a0", acc_addr.size() > 2 ? acc_addr[0] : -1, 32767);
    chk("awrap_a1", acc_addr.size() > 2 ? acc_addr[1] : -1, 0);
    chk("awrap_a2", acc_addr.size() > 2 ? acc_addr[2] : -1, 32767);
    chk("awrap_led", led_val.size() > 0 ? led_val[0] : -1, 32'h3AAAA);

    // length 0 and 1 with dwell 0: a fetch every 3 cycles.
    for (int l = 0; l < 2; l++) begin
      do_stop();
      do_start(32 + l, l, 0);
      repeat (13) tick();
      chk("short_fetches", acc_addr.size(), 5);
      chk("short_period", acc_cyc.size() > 1 ? acc_cyc[1] - acc_cyc[0] : -1, 3);
      chk("short_addr", acc_addr.size() > 4 ? acc_addr[4] : -1, 32 + l);
      chk("short_wraps", wrap_cnt, 4);
    end

    // Reset while fetching.
    bus_if.mem_grant = 1'b0;
    wait_cs(10);
    reset = 1; tick(); reset = 0;
    bus_if.mem_grant = 1'b1;
    chk("mrst_led", led, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_cs", bus_if.mem_chipselect, 0);
    chk("mrst_addr", bus_if.mem_address, 0);
    chk("mrst_wrap", wrap, 0);
    tick();

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus_if.mem_grant = ($urandom_range(3) != 0);
      start = ($urandom_range(7) == 0);
      if (start) begin
        base_addr = ADDR_W'($urandom);
        length    = ADDR_W'($urandom_range(0, 7));
        dwell     = DWELL_W'($urandom_range(0, 5));
      end
      stop  = ($urandom_range(63) == 0);
      reset = ($urandom_range(499) == 0);
      tick();
    end
    start = 0; stop = 0; reset = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
